// File: rtl/button_pulse_gen.sv
// Front-panel button conditioner: 2-flop sync, per-button debounce FSM, priority-encoded
// single-cycle command pulses. Optional auto-repeat of set/op1/op2 under `AUTOREPEAT_EN.

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
`ifdef AUTOREPEAT_EN
   ,
   parameter int HOLD_CYCLES     = 50000,
   parameter int REPEAT_CYCLES   = 10000,
   parameter bit CAN_REPEAT      = 1'b1
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_sync,
   output logic btn_level,
   output logic press_req
);

   typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter only runs inside a check state and restarts on every state change,
   // so it stops at DB_LAST and can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         RELEASED:    if (btn_sync) state_d = PRESS_CHK;
         PRESS_CHK: begin
            if (!btn_sync)             state_d = RELEASED;
            else if (cnt_q == DB_LAST) state_d = PRESSED;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         PRESSED:     if (!btn_sync) state_d = RELEASE_CHK;
         RELEASE_CHK: begin
            if (btn_sync)              state_d = PRESSED;
            else if (cnt_q == DB_LAST) state_d = RELEASED;
            else                       cnt_d   = cnt_q + 1'b1;
         end
         default:     state_d = RELEASED;
      endcase
   end

   always_comb begin
      btn_level = (state_q == PRESSED) || (state_q == RELEASE_CHK);
      press_hit = (state_q == PRESS_CHK) && btn_sync && (cnt_q == DB_LAST);
   end

`ifdef AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] hold_q;
   logic             rep_phase_q;
   logic             hold_hit;

   assign hold_hit  = (state_q == PRESSED) && btn_sync &&
                      (hold_q == (rep_phase_q ? REP_LAST : HOLD_LAST));
   assign press_req = press_hit || (CAN_REPEAT && hold_hit);

   // First repeat after HOLD_CYCLES, then every REPEAT_CYCLES; cleared whenever not staying PRESSED.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q      <= '0;
         rep_phase_q <= 1'b0;
      end else if (hold_hit) begin
         hold_q      <= '0;
         rep_phase_q <= 1'b1;
      end else if (state_q == PRESSED && btn_sync) begin
         hold_q      <= hold_q + 1'b1;
      end else begin
         hold_q      <= '0;
         rep_phase_q <= 1'b0;
      end
   end
`else
   assign press_req = press_hit;
`endif

endmodule

module button_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
`ifdef AUTOREPEAT_EN
   ,
   parameter int HOLD_CYCLES     = 50000,
   parameter int REPEAT_CYCLES   = 10000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic [3:0] cmd_pulse,
   output logic       cmd_valid
);

   localparam int NUM_BTN = 4;

   logic [NUM_BTN-1:0] sync_q1, sync_q2;
   logic [NUM_BTN-1:0] req, grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
`ifdef AUTOREPEAT_EN
         ,
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .CAN_REPEAT      (i != 3)
`endif
      ) u_btn (
         .clk       (clk),
         .reset     (reset),
         .btn_sync  (sync_q2[i]),
         .btn_level (btn_level[i]),
         .press_req (req[i])
      );
   end

   // Highest index wins (mode > set > op1 > op2); losing requests are dropped.
   always_comb begin
      grant = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (req[i] && grant == '0) grant[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cmd_pulse <= '0;
      else       cmd_pulse <= grant;
   end

   assign cmd_valid = |cmd_pulse;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: run-length debounce reference model, directed and random scenarios.
// Build with +define+AUTOREPEAT_EN to also exercise auto-repeat.

module tb_button_pulse_gen;

   localparam int D      = 4;
   localparam int HOLD   = 20;
   localparam int REPEAT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_raw = '0;
   logic [3:0] btn_level, cmd_pulse;
   logic       cmd_valid;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (16)
`ifdef AUTOREPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REPEAT)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .cmd_pulse (cmd_pulse),
      .cmd_valid (cmd_valid)
   );

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   // Reference: raw delayed two samples, level flips after D+1 consecutive opposite samples.
   logic [3:0] raw_d1, raw_d2, level_m, pulse_m;
   int         run_len[4];
   int         hold_t[4];

   function automatic logic [3:0] prio(input logic [3:0] r);
      for (int i = 3; i >= 0; i--) if (r[i]) return 4'(1 << i);
      return 4'b0000;
   endfunction

   task automatic model_reset();
      raw_d1 = '0; raw_d2 = '0; level_m = '0; pulse_m = '0;
      for (int b = 0; b < 4; b++) begin run_len[b] = 0; hold_t[b] = 0; end
   endtask

   task automatic model_step();
      logic [3:0] s, r;
      if (reset) begin model_reset(); return; end
      s = raw_d2; r = '0;
      for (int b = 0; b < 4; b++) begin
         if (s[b] != level_m[b]) run_len[b]++; else run_len[b] = 0;
         if (run_len[b] == D + 1) begin
            level_m[b] = ~level_m[b];
            run_len[b] = 0;
            if (level_m[b]) begin r[b] = 1'b1; hold_t[b] = 0; end
         end else if (level_m[b]) begin
            if (s[b]) hold_t[b]++; else hold_t[b] = -1;
`ifdef AUTOREPEAT_EN
            if (b != 3 && hold_t[b] >= HOLD && (hold_t[b] - HOLD) % REPEAT == 0) r[b] = 1'b1;
`endif
         end
      end
      pulse_m = prio(r);
      raw_d2 = raw_d1;
      raw_d1 = btn_raw;
   endtask

   // Advance one clock; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic settle(input int n);
      btn_raw = '0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_raw = '0; model_reset();
      tick(); tick();
      n_run++;
      if (cmd_pulse !== 4'b0 || btn_level !== 4'b0 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got pulse=%b level=%b valid=%b, expected all 0", cmd_pulse, btn_level, cmd_valid);
      end
      reset = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         n_run++;
         if (cmd_pulse !== 4'b0 || btn_level !== 4'b0 || cmd_valid !== 1'b0 || pulse_m !== 4'b0) begin
            n_fail++;
            $display("FAIL idle k=%0d got pulse=%b level=%b valid=%b, expected 0", k, cmd_pulse, btn_level, cmd_valid);
         end
      end
   endtask

   task automatic test_single_press();
      int npulse = 0;
      btn_raw = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         tick();
         n_run++;
         if (cmd_pulse !== ((k == 7) ? 4'b0010 : 4'b0000) || cmd_pulse !== pulse_m ||
             btn_level !== level_m || btn_level[1] !== (k >= 7) || cmd_valid !== (k == 7)) begin
            n_fail++;
            $display("FAIL single_press k=%0d got pulse=%b level=%b valid=%b, expected pulse=%b level=%b",
                     k, cmd_pulse, btn_level, cmd_valid, pulse_m, level_m);
         end
         if (cmd_valid) npulse++;
      end
      n_run++;
      if (npulse != 1) begin
         n_fail++;
         $display("FAIL single_press_count got %0d pulses, expected 1", npulse);
      end
      settle(12);
   endtask

   task automatic test_glitch();
      int npulse = 0;
      btn_raw = 4'b0100;
      for (int k = 0; k < 3; k++) tick();
      btn_raw = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_run++;
         if (cmd_pulse !== 4'b0 || btn_level[2] !== 1'b0 || btn_level !== level_m) begin
            n_fail++;
            $display("FAIL short_glitch k=%0d got pulse=%b level=%b, expected no pulse, level 0", k, cmd_pulse, btn_level);
         end
      end
      for (int k = 0; k < 10; k++) begin
         btn_raw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
         tick();
         if (cmd_valid) npulse++;
      end
      btn_raw = 4'b0100;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (cmd_valid) npulse++;
         n_run++;
         if (cmd_pulse !== pulse_m || btn_level !== level_m) begin
            n_fail++;
            $display("FAIL bounce k=%0d got pulse=%b level=%b, expected pulse=%b level=%b", k, cmd_pulse, btn_level, pulse_m, level_m);
         end
      end
      n_run++;
      if (npulse != 1 || btn_level !== 4'b0100) begin
         n_fail++;
         $display("FAIL bounce_count got %0d pulses level=%b, expected 1 pulse level=0100", npulse, btn_level);
      end
      settle(12);
   endtask

   task automatic test_simultaneous();
      int npulse = 0;
      btn_raw = 4'b1001;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (cmd_valid) npulse++;
         n_run++;
         if (cmd_pulse !== ((k == 7) ? 4'b1000 : 4'b0000) || cmd_pulse !== pulse_m ||
             cmd_valid !== (k == 7) || btn_level !== level_m) begin
            n_fail++;
            $display("FAIL simultaneous k=%0d got pulse=%b valid=%b level=%b, expected pulse=%b level=%b",
                     k, cmd_pulse, cmd_valid, btn_level, pulse_m, level_m);
         end
      end
      n_run++;
      if (npulse != 1 || btn_level !== 4'b1001) begin
         n_fail++;
         $display("FAIL simultaneous_final got %0d pulses level=%b, expected 1 pulse level=1001", npulse, btn_level);
      end
      settle(12);
   endtask

   task automatic test_reset_mid();
      btn_raw = 4'b0100;
      for (int k = 0; k < 9; k++) tick();
      n_run++;
      if (btn_level !== 4'b0100) begin
         n_fail++;
         $display("FAIL pre_reset_level got %b, expected 0100", btn_level);
      end
      #1 reset = 1'b1;
      #1;
      n_run++;
      if (btn_level !== 4'b0 || cmd_pulse !== 4'b0 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got level=%b pulse=%b, expected 0", btn_level, cmd_pulse);
      end
      model_reset();
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_run++;
         if (cmd_pulse !== ((k == 7) ? 4'b0100 : 4'b0000) || cmd_pulse !== pulse_m || btn_level !== level_m) begin
            n_fail++;
            $display("FAIL reset_repress k=%0d got pulse=%b level=%b, expected pulse=%b level=%b",
                     k, cmd_pulse, btn_level, pulse_m, level_m);
         end
      end
      // Reset while mid-debounce of a fresh press.
      settle(12);
      btn_raw = 4'b0001;
      for (int k = 0; k < 5; k++) tick();
      #1 reset = 1'b1;
      #1;
      n_run++;
      if (btn_level !== 4'b0 || cmd_pulse !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_mid_debounce got level=%b pulse=%b, expected 0", btn_level, cmd_pulse);
      end
      model_reset();
      tick();
      reset = 1'b0;
      settle(12);
   endtask

   task automatic test_random();
      int hold_left = 0;
      for (int k = 0; k < 600; k++) begin
         if (hold_left == 0) begin
            btn_raw   = 4'($urandom_range(0, 15));
            hold_left = $urandom_range(1, 9);
         end
         hold_left--;
         tick();
         n_run++;
         if (cmd_pulse !== pulse_m || btn_level !== level_m || cmd_valid !== (|pulse_m)) begin
            n_fail++;
            $display("FAIL random k=%0d raw=%b got pulse=%b level=%b valid=%b, expected pulse=%b level=%b",
                     k, btn_raw, cmd_pulse, btn_level, cmd_valid, pulse_m, level_m);
         end
      end
      settle(12);
   endtask

`ifdef AUTOREPEAT_EN
   task automatic test_autorepeat();
      int npulse = 0;
      btn_raw = 4'b0001;
      for (int k = 1; k <= 52; k++) begin
         tick();
         n_run++;
         if (cmd_pulse !== ((k == 7 || k == 27 || k == 35 || k == 43 || k == 51) ? 4'b0001 : 4'b0000) ||
             cmd_pulse !== pulse_m) begin
            n_fail++;
            $display("FAIL autorepeat k=%0d got pulse=%b, expected %b", k, cmd_pulse, pulse_m);
         end
      end
      settle(12);
      btn_raw = 4'b1000;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (cmd_valid) npulse++;
      end
      n_run++;
      if (npulse != 1) begin
         n_fail++;
         $display("FAIL mode_no_repeat got %0d pulses, expected 1", npulse);
      end
      settle(12);
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_random();
`ifdef AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
